// File: rtl/sdu1s2_dispatch_pkg.sv
// ----------------------------------------------------------------------------
// sdu1s2_dispatch_pkg
// Shared constants and types for the SDU single-stream to dual-channel
// packet dispatcher.
//   DATA_WIDTH : word width, [17] sop, [16] eop, [15:0] payload
//   SOP_BIT    : start-of-packet flag position
//   EOP_BIT    : end-of-packet flag position
//   U_DLY      : legacy unit drive delay (used by benches for input skew)
//   state_e    : dispatcher FSM encoding, also exported on debug_bus[15:14]
// ----------------------------------------------------------------------------
package sdu1s2_dispatch_pkg;

  localparam int DATA_WIDTH = 18;
  localparam int SOP_BIT    = 17;
  localparam int EOP_BIT    = 16;
  localparam int U_DLY      = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_e;

endpackage

// File: rtl/sdu1s2_dispatch_if.sv
// ----------------------------------------------------------------------------
// sdu1s2_dispatch_if
// Upstream FIFO read port and the two downstream channel write ports of the
// SDU dispatcher.
//   src_sdu_empty  : upstream FIFO empty
//   sdu_src_rden   : upstream read enable (data returns one cycle later)
//   src_sdu_dval   : upstream read data valid
//   src_sdu_data   : upstream read data
//   chn_sdu_afull  : per-channel downstream almost-full
//   sdu_chn_wren   : per-channel write enable, one-hot or zero
//   sdu_chn_wdata  : write data shared by both channels
// Modports: master = dispatcher side, slave = FIFO/environment side.
// ----------------------------------------------------------------------------
interface sdu1s2_dispatch_if #(
  parameter int DATA_WIDTH = sdu1s2_dispatch_pkg::DATA_WIDTH
);
  import sdu1s2_dispatch_pkg::*;

  logic                  src_sdu_empty;
  logic                  sdu_src_rden;
  logic                  src_sdu_dval;
  logic [DATA_WIDTH-1:0] src_sdu_data;
  logic [1:0]            chn_sdu_afull;
  logic [1:0]            sdu_chn_wren;
  logic [DATA_WIDTH-1:0] sdu_chn_wdata;

  modport master (
    input  src_sdu_empty, src_sdu_dval, src_sdu_data, chn_sdu_afull,
    output sdu_src_rden, sdu_chn_wren, sdu_chn_wdata
  );

  modport slave (
    output src_sdu_empty, src_sdu_dval, src_sdu_data, chn_sdu_afull,
    input  sdu_src_rden, sdu_chn_wren, sdu_chn_wdata
  );

endinterface

// File: rtl/sdu1s2_dispatch.sv
// ----------------------------------------------------------------------------
// sdu1s2_dispatch
// Reads sop/eop-framed words from one upstream FIFO and steers each whole
// packet into channel 0 or channel 1, chosen by payload bit DEST_BIT of the
// head word.
// Ports:
//   clk_sys   : system clock
//   rst_sys   : asynchronous active-low reset
//   chip_cs   : dispatch enable; low stops new upstream reads
//   bus       : sdu1s2_dispatch_if.master (upstream read + channel writes)
//   debug_bus : [15:14] state, [13] dest, [12] read outstanding,
//               [11:8] error count, [7:0] packet count
// Build option: SDU1S2_ERRCNT_EN adds the 4-bit saturating error counter;
// without it debug_bus[11:8] reads 0 (orphans/premature heads still handled).
// ----------------------------------------------------------------------------
module sdu1s2_dispatch
  import sdu1s2_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH = sdu1s2_dispatch_pkg::DATA_WIDTH,
  parameter int DEST_BIT   = 0
) (
  input  logic                   clk_sys,
  input  logic                   rst_sys,
  input  logic                   chip_cs,
  sdu1s2_dispatch_if.master      bus,
  output logic [15:0]            debug_bus
);

  state_e                state, state_n;
  logic                  dest, dest_n;
  logic                  rd_out;
  logic [7:0]            pkt_cnt;
  logic [3:0]            err_field;
  logic                  rden;
  logic                  pkt_open, open_n;
  logic                  wr_en, wr_dest, pkt_inc, err_inc;
  logic                  vld_p1, sop_p1, eop_p1;
  logic [1:0]            wren_p2;
  logic [DATA_WIDTH-1:0] wdata_p2;

  // ---- stage p1: word returned by the upstream FIFO ----
  assign vld_p1 = bus.src_sdu_dval;
  assign sop_p1 = bus.src_sdu_data[SOP_BIT];
  assign eop_p1 = bus.src_sdu_data[EOP_BIT];

  // Read issue. HEAD never reads ahead because the destination is unknown;
  // BODY refuses to read alongside an eop so the next head is never
  // pre-read under the closing packet's destination.
  always_comb begin
    rden = 1'b0;
    unique case (state)
      ST_IDLE: rden = chip_cs & ~bus.src_sdu_empty;
      ST_BODY: rden = chip_cs & ~bus.src_sdu_empty & ~bus.chn_sdu_afull[dest]
                      & ~(vld_p1 & eop_p1);
      default: rden = 1'b0;
    endcase
  end

  // Gated by reset so the port reads 0 while rst_sys is held low.
  assign bus.sdu_src_rden = rden & rst_sys;

  // Word handling and next state.
  always_comb begin
    pkt_open = (state == ST_BODY);
    open_n   = pkt_open;
    dest_n   = dest;
    wr_en    = 1'b0;
    wr_dest  = dest;
    pkt_inc  = 1'b0;
    err_inc  = 1'b0;
    if (vld_p1) begin
      if (sop_p1) begin
        // A head, expected or premature; a premature one restarts the
        // packet under the new destination without repairing the old one.
        dest_n  = bus.src_sdu_data[DEST_BIT];
        wr_dest = bus.src_sdu_data[DEST_BIT];
        wr_en   = 1'b1;
        err_inc = pkt_open;
        open_n  = ~eop_p1;
        pkt_inc = eop_p1;
      end else if (pkt_open) begin
        wr_en   = 1'b1;
        open_n  = ~eop_p1;
        pkt_inc = eop_p1;
      end else begin
        // Orphan body word: dropped.
        err_inc = 1'b1;
        open_n  = 1'b0;
      end
    end
    if (open_n) begin
      state_n = ST_BODY;
    end else if (rden || (state == ST_HEAD && !vld_p1)) begin
      state_n = ST_HEAD;
    end else begin
      state_n = ST_IDLE;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      state   <= ST_IDLE;
      dest    <= 1'b0;
      rd_out  <= 1'b0;
      pkt_cnt <= 8'd0;
    end else begin
      state   <= state_n;
      dest    <= dest_n;
      rd_out  <= rden;
      pkt_cnt <= pkt_cnt + {7'd0, pkt_inc};
    end
  end

  // ---- stage p2: registered channel write ----
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      wren_p2  <= 2'b00;
      wdata_p2 <= '0;
    end else begin
      wren_p2 <= wr_en ? (wr_dest ? 2'b10 : 2'b01) : 2'b00;
      if (wr_en) begin
        wdata_p2 <= bus.src_sdu_data;
      end
    end
  end

  assign bus.sdu_chn_wren  = wren_p2;
  assign bus.sdu_chn_wdata = wdata_p2;

`ifdef SDU1S2_ERRCNT_EN
  logic [3:0] err_cnt;

  function automatic logic [3:0] sat_inc4(input logic [3:0] cnt);
    return (cnt == 4'hF) ? cnt : cnt + 4'd1;
  endfunction

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      err_cnt <= 4'd0;
    end else if (err_inc) begin
      err_cnt <= sat_inc4(err_cnt);
    end
  end

  assign err_field = err_cnt;
`else
  logic err_inc_unused;
  assign err_inc_unused = err_inc;
  assign err_field      = 4'd0;
`endif

  assign debug_bus = {2'(state), dest, rd_out, err_field, pkt_cnt};

endmodule

// File: tb/tb_sdu1s2_dispatch.sv
`timescale 1ns/1ps
module tb_sdu1s2_dispatch;
  import sdu1s2_dispatch_pkg::*;

`ifdef SDU1S2_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        rst_sys;
  logic        chip_cs;
  logic [15:0] debug_bus;

  sdu1s2_dispatch_if #(.DATA_WIDTH(18)) bus ();

  sdu1s2_dispatch #(.DATA_WIDTH(18), .DEST_BIT(0)) dut (
    .clk_sys  (clk_sys),
    .rst_sys  (rst_sys),
    .chip_cs  (chip_cs),
    .bus      (bus),
    .debug_bus(debug_bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_pkt = 0;
  int err_raw = 0;

  // Upstream FIFO model: words queued by the stimulus, popped one cycle
  // after the DUT's read enable is seen.
  logic [17:0] stim [0:63];
  int          stim_wr = 0;
  int          stim_rd = 0;
  logic        up_dval  = 1'b0;
  logic        up_empty = 1'b1;
  logic [17:0] up_data  = '0;
  logic        rd_hit   = 1'b0;
  logic [1:0]  dn_afull = 2'b00;

  assign bus.src_sdu_dval  = up_dval;
  assign bus.src_sdu_empty = up_empty;
  assign bus.src_sdu_data  = up_data;
  assign bus.chn_sdu_afull = dn_afull;

  always @(negedge clk_sys) rd_hit = bus.sdu_src_rden;

  always @(posedge clk_sys) begin
    #(U_DLY);
    if (rd_hit && stim_rd != stim_wr) begin
      up_dval = 1'b1;
      up_data = stim[stim_rd];
      stim_rd = stim_rd + 1;
    end else begin
      up_dval = 1'b0;
    end
    up_empty = (stim_rd == stim_wr);
  end

  // Channel monitor.
  logic [17:0] ch0_log [0:63];
  logic [17:0] ch1_log [0:63];
  time         ch1_t   [0:63];
  int ch0_n = 0, ch1_n = 0, both_n = 0;

  always @(negedge clk_sys) begin
    if (bus.sdu_chn_wren == 2'b01) begin
      ch0_log[ch0_n] = bus.sdu_chn_wdata; ch0_n++;
    end else if (bus.sdu_chn_wren == 2'b10) begin
      ch1_log[ch1_n] = bus.sdu_chn_wdata; ch1_t[ch1_n] = $time; ch1_n++;
    end else if (bus.sdu_chn_wren == 2'b11) begin
      both_n++;
    end
  end

  task automatic push(input logic [17:0] w);
    stim[stim_wr] = w;
    stim_wr = stim_wr + 1;
  endtask

  task automatic wait_done(input string name);
    int  n = 0;
    bit  done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk_sys);
      done = (stim_rd == stim_wr) && !up_dval && (debug_bus[15:14] == 2'd0)
             && !debug_bus[12] && (bus.sdu_chn_wren == 2'b00);
      n++;
    end
    vectors++; if (!done) begin miscompares++; $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n); end
  endtask

  task automatic test_reset();
    rst_sys = 1'b1; chip_cs = 1'b0; dn_afull = 2'b00;
    #2 rst_sys = 1'b0;
    repeat (3) @(negedge clk_sys);
    vectors++; if (debug_bus !== 16'h0000) begin miscompares++; $display("FAIL rst_debug: got %h, required 0000", debug_bus); end
    vectors++; if (bus.sdu_chn_wren !== 2'b00) begin miscompares++; $display("FAIL rst_wren: got %b, required 00", bus.sdu_chn_wren); end
    vectors++; if (bus.sdu_chn_wdata !== 18'h0) begin miscompares++; $display("FAIL rst_wdata: got %h, required 0", bus.sdu_chn_wdata); end
    vectors++; if (bus.sdu_src_rden !== 1'b0) begin miscompares++; $display("FAIL rst_rden: got %b, required 0", bus.sdu_src_rden); end
    @(posedge clk_sys); #(U_DLY);
    rst_sys = 1'b1; chip_cs = 1'b1;
    @(negedge clk_sys);
    vectors++; if (debug_bus !== 16'h0000) begin miscompares++; $display("FAIL rel_debug: got %h, required 0000", debug_bus); end
  endtask

  task automatic test_dest1();
    int  c0 = ch0_n, c1 = ch1_n;
    bit  seen = 1'b0;
    time t_rd = 0;
    push(18'h20001); push(18'h00055); push(18'h10077);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_sys);
      if (bus.sdu_src_rden === 1'b1) begin seen = 1'b1; t_rd = $time; end
    end
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL d1_rden_seen: got %b, required 1", seen); end
    wait_done("d1");
    exp_pkt++;
    vectors++; if (ch1_n - c1 !== 3) begin miscompares++; $display("FAIL d1_ch1_count: got %0d, required 3", ch1_n - c1); end
    vectors++; if (ch0_n - c0 !== 0) begin miscompares++; $display("FAIL d1_ch0_count: got %0d, required 0", ch0_n - c0); end
    vectors++; if (ch1_log[c1] !== 18'h20001) begin miscompares++; $display("FAIL d1_w0: got %h, required 20001", ch1_log[c1]); end
    vectors++; if (ch1_log[c1+1] !== 18'h00055) begin miscompares++; $display("FAIL d1_w1: got %h, required 00055", ch1_log[c1+1]); end
    vectors++; if (ch1_log[c1+2] !== 18'h10077) begin miscompares++; $display("FAIL d1_w2: got %h, required 10077", ch1_log[c1+2]); end
    vectors++; if ((ch1_t[c1] - t_rd) !== 64'd20) begin miscompares++; $display("FAIL d1_head_lat: got %0t, required 20", ch1_t[c1] - t_rd); end
    vectors++; if ((ch1_t[c1+2] - ch1_t[c1+1]) !== 64'd10) begin miscompares++; $display("FAIL d1_body_rate: got %0t, required 10", ch1_t[c1+2] - ch1_t[c1+1]); end
    vectors++; if (debug_bus[7:0] !== 8'(exp_pkt)) begin miscompares++; $display("FAIL d1_pkt: got %0d, required %0d", debug_bus[7:0], exp_pkt); end
  endtask

  task automatic test_back_to_back();
    int c0 = ch0_n, c1 = ch1_n, b0 = both_n;
    logic [17:0] e0 [0:2] = '{18'h20000, 18'h00011, 18'h10022};
    logic [17:0] e1 [0:1] = '{18'h20003, 18'h10044};
    for (int i = 0; i < 3; i++) push(e0[i]);
    for (int i = 0; i < 2; i++) push(e1[i]);
    wait_done("b2b");
    exp_pkt += 2;
    vectors++; if (ch0_n - c0 !== 3) begin miscompares++; $display("FAIL b2b_ch0_count: got %0d, required 3", ch0_n - c0); end
    vectors++; if (ch1_n - c1 !== 2) begin miscompares++; $display("FAIL b2b_ch1_count: got %0d, required 2", ch1_n - c1); end
    vectors++; if (both_n - b0 !== 0) begin miscompares++; $display("FAIL b2b_both: got %0d, required 0", both_n - b0); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (ch0_log[c0+i] !== e0[i]) begin miscompares++; $display("FAIL b2b_ch0_w%0d: got %h, required %h", i, ch0_log[c0+i], e0[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      vectors++; if (ch1_log[c1+i] !== e1[i]) begin miscompares++; $display("FAIL b2b_ch1_w%0d: got %h, required %h", i, ch1_log[c1+i], e1[i]); end
    end
    vectors++; if (debug_bus[7:0] !== 8'(exp_pkt)) begin miscompares++; $display("FAIL b2b_pkt: got %0d, required %0d", debug_bus[7:0], exp_pkt); end
  endtask

  task automatic test_backpressure();
    int c0 = ch0_n, n_at, viol = 0, k = 0;
    logic [17:0] e [0:7] = '{18'h20000, 18'h00101, 18'h00102, 18'h00103,
                             18'h00104, 18'h00105, 18'h00106, 18'h10107};
    for (int i = 0; i < 8; i++) push(e[i]);
    while (ch0_n - c0 < 2 && k < 50) begin @(negedge clk_sys); k++; end
    @(posedge clk_sys); #(U_DLY);
    dn_afull = 2'b01;
    #1;
    vectors++; if (bus.sdu_src_rden !== 1'b0) begin miscompares++; $display("FAIL bp_rden_same_cycle: got %b, required 0", bus.sdu_src_rden); end
    n_at = ch0_n;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (bus.sdu_src_rden !== 1'b0) viol++;
    end
    vectors++; if (viol !== 0) begin miscompares++; $display("FAIL bp_rden_held: got %0d reads, required 0", viol); end
    vectors++; if (ch0_n - n_at > 3) begin miscompares++; $display("FAIL bp_extra_writes: got %0d, required <=3", ch0_n - n_at); end
    @(posedge clk_sys); #(U_DLY);
    dn_afull = 2'b00;
    wait_done("bp");
    exp_pkt++;
    vectors++; if (ch0_n - c0 !== 8) begin miscompares++; $display("FAIL bp_count: got %0d, required 8", ch0_n - c0); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (ch0_log[c0+i] !== e[i]) begin miscompares++; $display("FAIL bp_w%0d: got %h, required %h", i, ch0_log[c0+i], e[i]); end
    end
    vectors++; if (debug_bus[7:0] !== 8'(exp_pkt)) begin miscompares++; $display("FAIL bp_pkt: got %0d, required %0d", debug_bus[7:0], exp_pkt); end
  endtask

  task automatic test_orphan();
    int c0 = ch0_n, c1 = ch1_n;
    push(18'h00033);
    wait_done("orph");
    err_raw++;
    vectors++; if ((ch0_n - c0) + (ch1_n - c1) !== 0) begin miscompares++; $display("FAIL orph_writes: got %0d, required 0", (ch0_n - c0) + (ch1_n - c1)); end
    vectors++; if (debug_bus[15:14] !== 2'd0) begin miscompares++; $display("FAIL orph_state: got %0d, required 0", debug_bus[15:14]); end
    vectors++; if (debug_bus[11:8] !== (ERRCNT_ON ? 4'(err_raw) : 4'd0)) begin miscompares++; $display("FAIL orph_err: got %0d, required %0d", debug_bus[11:8], ERRCNT_ON ? err_raw : 0); end
    push(18'h20001); push(18'h10009);
    wait_done("orph_next");
    exp_pkt++;
    vectors++; if (ch1_n - c1 !== 2) begin miscompares++; $display("FAIL orph_next_count: got %0d, required 2", ch1_n - c1); end
    vectors++; if (ch1_log[c1] !== 18'h20001) begin miscompares++; $display("FAIL orph_next_w0: got %h, required 20001", ch1_log[c1]); end
    vectors++; if (ch1_log[c1+1] !== 18'h10009) begin miscompares++; $display("FAIL orph_next_w1: got %h, required 10009", ch1_log[c1+1]); end
    vectors++; if (debug_bus[7:0] !== 8'(exp_pkt)) begin miscompares++; $display("FAIL orph_pkt: got %0d, required %0d", debug_bus[7:0], exp_pkt); end
  endtask

  task automatic test_single_word();
    int c0 = ch0_n, c1 = ch1_n;
    push(18'h30000);
    wait_done("sw");
    exp_pkt++;
    vectors++; if (ch0_n - c0 !== 1) begin miscompares++; $display("FAIL sw_ch0_count: got %0d, required 1", ch0_n - c0); end
    vectors++; if (ch1_n - c1 !== 0) begin miscompares++; $display("FAIL sw_ch1_count: got %0d, required 0", ch1_n - c1); end
    vectors++; if (ch0_log[c0] !== 18'h30000) begin miscompares++; $display("FAIL sw_word: got %h, required 30000", ch0_log[c0]); end
    vectors++; if (debug_bus[15:14] !== 2'd0) begin miscompares++; $display("FAIL sw_state: got %0d, required 0", debug_bus[15:14]); end
    vectors++; if (debug_bus[7:0] !== 8'(exp_pkt)) begin miscompares++; $display("FAIL sw_pkt: got %0d, required %0d", debug_bus[7:0], exp_pkt); end
  endtask

  task automatic test_premature_head();
    int c0 = ch0_n, c1 = ch1_n;
    push(18'h20000); push(18'h00001); push(18'h20001); push(18'h10002);
    wait_done("pre");
    exp_pkt++;
    err_raw++;
    vectors++; if (ch0_n - c0 !== 2) begin miscompares++; $display("FAIL pre_ch0_count: got %0d, required 2", ch0_n - c0); end
    vectors++; if (ch1_n - c1 !== 2) begin miscompares++; $display("FAIL pre_ch1_count: got %0d, required 2", ch1_n - c1); end
    vectors++; if (ch0_log[c0+1] !== 18'h00001) begin miscompares++; $display("FAIL pre_ch0_w1: got %h, required 00001", ch0_log[c0+1]); end
    vectors++; if (ch1_log[c1] !== 18'h20001) begin miscompares++; $display("FAIL pre_ch1_w0: got %h, required 20001", ch1_log[c1]); end
    vectors++; if (ch1_log[c1+1] !== 18'h10002) begin miscompares++; $display("FAIL pre_ch1_w1: got %h, required 10002", ch1_log[c1+1]); end
    vectors++; if (debug_bus[11:8] !== (ERRCNT_ON ? 4'(err_raw) : 4'd0)) begin miscompares++; $display("FAIL pre_err: got %0d, required %0d", debug_bus[11:8], ERRCNT_ON ? err_raw : 0); end
    vectors++; if (debug_bus[7:0] !== 8'(exp_pkt)) begin miscompares++; $display("FAIL pre_pkt: got %0d, required %0d", debug_bus[7:0], exp_pkt); end
  endtask

  task automatic test_reset_mid();
    int c0, c1, k = 0;
    bit in_body = 1'b0;
    logic [17:0] e [0:2] = '{18'h20000, 18'h00BBB, 18'h10CCC};
    push(18'h20001); push(18'h00AAA);
    while (!in_body && k < 30) begin
      @(negedge clk_sys); k++;
      in_body = (debug_bus[15:14] == 2'd2) && (stim_rd == stim_wr) && !up_dval
                && (bus.sdu_chn_wren == 2'b00);
    end
    vectors++; if (in_body !== 1'b1) begin miscompares++; $display("FAIL rm_in_body: got %b, required 1", in_body); end
    @(posedge clk_sys); #(U_DLY);
    rst_sys = 1'b0;
    repeat (2) @(negedge clk_sys);
    vectors++; if (debug_bus !== 16'h0000) begin miscompares++; $display("FAIL rm_debug: got %h, required 0000", debug_bus); end
    vectors++; if (bus.sdu_chn_wren !== 2'b00) begin miscompares++; $display("FAIL rm_wren: got %b, required 00", bus.sdu_chn_wren); end
    vectors++; if (bus.sdu_chn_wdata !== 18'h0) begin miscompares++; $display("FAIL rm_wdata: got %h, required 0", bus.sdu_chn_wdata); end
    vectors++; if (bus.sdu_src_rden !== 1'b0) begin miscompares++; $display("FAIL rm_rden: got %b, required 0", bus.sdu_src_rden); end
    @(posedge clk_sys); #(U_DLY);
    rst_sys = 1'b1;
    exp_pkt = 0;
    err_raw = 0;
    c0 = ch0_n; c1 = ch1_n;
    for (int i = 0; i < 3; i++) push(e[i]);
    wait_done("rm");
    exp_pkt++;
    vectors++; if (ch0_n - c0 !== 3) begin miscompares++; $display("FAIL rm_ch0_count: got %0d, required 3", ch0_n - c0); end
    vectors++; if (ch1_n - c1 !== 0) begin miscompares++; $display("FAIL rm_ch1_count: got %0d, required 0", ch1_n - c1); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (ch0_log[c0+i] !== e[i]) begin miscompares++; $display("FAIL rm_w%0d: got %h, required %h", i, ch0_log[c0+i], e[i]); end
    end
    vectors++; if (debug_bus[11:0] !== {4'd0, 8'(exp_pkt)}) begin miscompares++; $display("FAIL rm_counters: got %h, required %h", debug_bus[11:0], exp_pkt); end
  endtask

  initial begin
    test_reset();
    test_dest1();
    test_back_to_back();
    test_backpressure();
    test_orphan();
    test_single_word();
    test_premature_head();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
